// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the hazard controller.
// These are the Tuse/Tnew encodings and the default MDU latencies.
package pipe_hazard_ctrl_pkg;

   localparam int TW = 2;

   localparam logic [TW-1:0] TUSE_NONE   = 2'd3;

   // Tnew per instruction class and stage; 0 means already forwardable
   localparam logic [TW-1:0] TNEW_ALU_E  = 2'd1;
   localparam logic [TW-1:0] TNEW_LOAD_E = 2'd2;
   localparam logic [TW-1:0] TNEW_LOAD_M = 2'd1;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Counts down the cycles the multiply/divide unit stays busy after an md op leaves E.
// A new start reloads the counter even while a previous op is still counting.
module pipe_hazard_ctrl_md_busy_cnt #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CW       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   logic [CW-1:0] md_cnt_q;
   logic [CW-1:0] md_cnt_d;

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_start) begin
         md_cnt_d = md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: holds F and D and bubbles E when a D operand is not ready.
// Stall is combinational from D/E/M state; only the MDU counter and stall count are registered.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    D_rs,
   input  logic [4:0]    D_rt,
   input  logic [TW-1:0] D_rs_tuse,
   input  logic [TW-1:0] D_rt_tuse,
   input  logic          D_is_md,
   input  logic [4:0]    E_A3,
   input  logic [TW-1:0] E_tnew,
   input  logic [4:0]    M_A3,
   input  logic [TW-1:0] M_tnew,
   input  logic          E_md_start,
   input  logic          E_md_is_div,
   output logic          F_WE,
   output logic          D_WE,
   output logic          E_clr,
   output logic          md_busy,
   output logic [31:0]   stall_cnt
);

   logic        rs_stall;
   logic        rt_stall;
   logic        md_stall;
   logic        stall;
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   pipe_hazard_ctrl_md_busy_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CW       (CW)
   ) u_md_busy_cnt (
      .clk       (clk),
      .rst       (rst),
      .md_start  (E_md_start),
      .md_is_div (E_md_is_div),
      .md_busy   (md_busy)
   );

   // $0 never carries a dependency; equal Tnew/Tuse is covered by forwarding
   always_comb begin
      rs_stall = 1'b0;
      rt_stall = 1'b0;
      if (D_rs != 5'd0 && D_rs_tuse != TUSE_NONE) begin
         rs_stall = (D_rs == E_A3 && E_tnew > D_rs_tuse) ||
                    (D_rs == M_A3 && M_tnew > D_rs_tuse);
      end
      if (D_rt != 5'd0 && D_rt_tuse != TUSE_NONE) begin
         rt_stall = (D_rt == E_A3 && E_tnew > D_rt_tuse) ||
                    (D_rt == M_A3 && M_tnew > D_rt_tuse);
      end
      md_stall = D_is_md && (E_md_start || md_busy);
      stall    = rs_stall || rt_stall || md_stall;
   end

   assign F_WE  = ~stall;
   assign D_WE  = ~stall;
   assign E_clr = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: hazard vector table, MDU/reset/saturation sequences, random run vs model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int MLAT = MULT_LAT_DEF;
   localparam int DLAT = DIV_LAT_DEF;

   logic        clk;
   logic        rst;
   logic [4:0]  D_rs, D_rt, E_A3, M_A3;
   logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
   logic        D_is_md, E_md_start, E_md_is_div;
   logic        F_WE, D_WE, E_clr, md_busy;
   logic [31:0] stall_cnt;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
      .D_is_md(D_is_md), .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
      .F_WE(F_WE), .D_WE(D_WE), .E_clr(E_clr), .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   // Model: the MDU is busy during the LAT cycles following the cycle of the latest start
   longint cyc;
   longint md_start_cyc;
   int     md_lat;
   longint m_cnt;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
      return (r != 0) && (tu != 2'd3) &&
             ((r == E_A3 && E_tnew > tu) || (r == M_A3 && M_tnew > tu));
   endfunction

   function automatic bit m_busy();
      return (cyc > md_start_cyc) && (cyc <= md_start_cyc + md_lat);
   endfunction

   function automatic bit m_stall();
      return hz(D_rs, D_rs_tuse) || hz(D_rt, D_rt_tuse) ||
             (D_is_md && (E_md_start || m_busy()));
   endfunction

   task automatic model_reset();
      md_start_cyc = -1000;
      md_lat       = 0;
      m_cnt        = 0;
   endtask

   // Compare this cycle's outputs, then advance one clock and the model with it
   task automatic step(input string nm);
      bit s;
      #1;
      s = m_stall();
      check({nm, ".ctl"}, {F_WE, D_WE, E_clr, md_busy}, {~s, ~s, s, m_busy()});
      check({nm, ".cnt"}, stall_cnt, m_cnt);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (E_md_start) begin
            md_start_cyc = cyc;
            md_lat       = E_md_is_div ? DLAT : MLAT;
         end
         if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      cyc++;
      #1;
   endtask

   task automatic idle();
      D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 0;
      E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0; E_md_start = 0; E_md_is_div = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle();
      step("rst");
      rst = 0;
   endtask

   typedef struct {
      logic [4:0] rs; logic [1:0] rs_tu;
      logic [4:0] rt; logic [1:0] rt_tu;
      logic [4:0] ea3; logic [1:0] etn;
      logic [4:0] ma3; logic [1:0] mtn;
      bit         exp_stall;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int n;
      int busy_n;
      rst = 1; idle();
      cyc = 0; model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;

      check("reset_ctl", {F_WE, D_WE, E_clr, md_busy}, 4'b1100);
      check("reset_cnt", stall_cnt, 0);

      vecs[0] = '{1, 2'd1, 0, 2'd3, 1, TNEW_LOAD_E, 0, 0, 1};   // lw in E, add rs
      vecs[1] = '{1, 2'd1, 0, 2'd3, 0, 0, 1, TNEW_LOAD_M, 0};   // lw now in M
      vecs[2] = '{1, 2'd0, 0, 2'd3, 1, TNEW_ALU_E, 0, 0, 1};    // add in E, beq
      vecs[3] = '{0, 2'd0, 0, 2'd3, 0, TNEW_ALU_E, 0, 0, 0};    // $0 never stalls
      vecs[4] = '{1, 2'd3, 0, 2'd3, 1, 2'd2, 0, 0, 0};          // rs unused
      vecs[5] = '{0, 2'd3, 5, 2'd0, 0, 0, 5, 2'd1, 1};          // rt vs M
      vecs[6] = '{0, 2'd3, 5, 2'd1, 0, 0, 5, 2'd1, 0};          // Tnew == Tuse
      vecs[7] = '{2, 2'd0, 0, 2'd3, 3, 2'd2, 0, 0, 0};          // other register
      vecs[8] = '{0, 2'd3, 7, 2'd1, 7, 2'd2, 0, 0, 1};          // rt vs E
      vecs[9] = '{4, 2'd2, 0, 2'd3, 4, 2'd2, 0, 0, 0};          // equal at 2
      for (int i = 0; i < 10; i++) begin
         idle();
         D_rs = vecs[i].rs; D_rs_tuse = vecs[i].rs_tu;
         D_rt = vecs[i].rt; D_rt_tuse = vecs[i].rt_tu;
         E_A3 = vecs[i].ea3; E_tnew = vecs[i].etn;
         M_A3 = vecs[i].ma3; M_tnew = vecs[i].mtn;
         #1;
         check($sformatf("vec%0d", i), {F_WE, D_WE, E_clr}, vecs[i].exp_stall ? 3'b001 : 3'b110);
         step($sformatf("vec%0d", i));
      end

      // div in E with mflo in D: stalled for the start cycle plus DLAT busy cycles
      do_reset();
      idle(); D_is_md = 1; E_md_start = 1; E_md_is_div = 1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (E_clr) n++;
         else break;
         step("div");
         E_md_start = 0;
      end
      check("div_stall_cycles", n, DLAT + 1);
      check("div_busy_low", md_busy, 0);
      check("div_stall_cnt", stall_cnt, DLAT + 1);
      step("div_after");

      // mult with an unrelated D instruction: no stall, busy for MLAT cycles
      do_reset();
      idle(); D_rs = 3; D_rs_tuse = 1; E_md_start = 1;
      step("mult");
      E_md_start = 0;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (md_busy) busy_n++;
         step("mult_busy");
      end
      check("mult_busy_cycles", busy_n, MLAT);
      check("mult_no_stall", stall_cnt, 0);

      // reset in the middle of a divide while mfhi waits in D
      do_reset();
      idle(); E_md_start = 1; E_md_is_div = 1;
      step("div2");
      E_md_start = 0;
      for (int i = 0; i < 4; i++) step("div2_wait");
      D_is_md = 1; rst = 1;
      #1;
      check("rst_mid_stall", E_clr, 1);
      step("rst_mid");
      rst = 0;
      #1;
      check("rst_mid_release", {F_WE, D_WE, E_clr, md_busy}, 4'b1100);
      check("rst_mid_cnt", stall_cnt, 0);
      step("post_rst");

      // saturation from a preloaded count
      do_reset();
      idle(); D_rs = 1; D_rs_tuse = 1; E_A3 = 1; E_tnew = 2;
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 64'hFFFF_FFFE;
      step("sat0");
      check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) step("sat_hold");
      check("sat_hold_final", stall_cnt, 32'hFFFF_FFFF);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         D_rs        = 5'($urandom_range(0, 3));
         D_rt        = 5'($urandom_range(0, 3));
         D_rs_tuse   = 2'($urandom_range(0, 3));
         D_rt_tuse   = 2'($urandom_range(0, 3));
         E_A3        = 5'($urandom_range(0, 3));
         M_A3        = 5'($urandom_range(0, 3));
         E_tnew      = 2'($urandom_range(0, 2));
         M_tnew      = 2'($urandom_range(0, 1));
         D_is_md     = ($urandom_range(0, 2) == 0);
         E_md_start  = ($urandom_range(0, 9) == 0);
         E_md_is_div = 1'($urandom_range(0, 1));
         rst         = ($urandom_range(0, 60) == 0);
         step("rand");
      end
      rst = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
